// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int data_width = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                            wclk,
    input  logic                            w_rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*data_width-1:0]   req_data,
    input  logic                            full,
    output logic [NUM_REQ-1:0]              ack,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            w_en,
    output logic [data_width-1:0]           data_in,
    output logic                            busy
);
    localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
    localparam int OW = $clog2(NUM_REQ);
    typedef enum logic {IDLE, OWN} state_t;
    state_t        state;
    logic [BW-1:0] beat_cnt;
    logic [OW-1:0] last_owner;
    logic [OW-1:0] winner;
    logic          xfer;
    // last_owner doubles as the current owner index while in OWN
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_owner) + k) % NUM_REQ]) winner = OW'((int'(last_owner) + k) % NUM_REQ);
        end
    end
    always_comb begin
        xfer    = w_rst_n && state == OWN && req[last_owner] && !full;
        w_en    = xfer;
        ack     = grant & {NUM_REQ{xfer}};
        busy    = state == OWN;
        data_in = state == OWN ? req_data[int'(last_owner)*data_width +: data_width] : '0;
    end
    always_ff @(posedge wclk) begin
        if (!w_rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            beat_cnt   <= '0;
            last_owner <= OW'(NUM_REQ - 1);
        end else if (state == IDLE) begin
            if (|req) begin
                state      <= OWN;
                grant      <= NUM_REQ'(1) << winner;
                last_owner <= winner;
                beat_cnt   <= '0;
            end
        end else if (!req[last_owner] || (!full && beat_cnt == BW'(MAX_BURST - 1))) begin
            state <= IDLE;
            grant <= '0;
        end else if (!full) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed-vector checks of grant rotation, bursts, stalls, release and reset
module tb_fifo_wr_arbiter;
    logic        wclk = 0;
    logic        w_rst_n = 0;
    logic        full = 0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack, grant;
    logic        w_en, busy;
    logic [7:0]  data_in;
    int checks = 0;
    int errors = 0;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.NUM_REQ(4), .data_width(8), .MAX_BURST(4)) dut (
        .wclk(wclk), .w_rst_n(w_rst_n), .req(req), .req_data(req_data), .full(full),
        .ack(ack), .grant(grant), .w_en(w_en), .data_in(data_in), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge wclk);
        #1;
    endtask

    // Sample all outputs mid-cycle against the expected owner/write/data
    task automatic see(input string tag, input logic [3:0] g, input logic we, input logic [7:0] d);
        #1;
        check({tag, ".grant"}, grant, g);
        check({tag, ".w_en"}, w_en, we);
        check({tag, ".ack"}, ack, we ? g : 4'b0);
        check({tag, ".data"}, data_in, d);
        check({tag, ".busy"}, busy, g != 0);
    endtask

    task automatic do_reset();
        w_rst_n = 0;
        req = '0;
        full = 0;
        cyc();
        cyc();
        w_rst_n = 1;
    endtask

    initial begin
        do_reset();
        w_rst_n = 0;
        cyc();
        see("rst", 4'b0, 1'b0, 8'h00);
        w_rst_n = 1;

        req = 4'b0010; req_data = 32'h0000A100;
        see("t1_idle", 4'b0, 1'b0, 8'h00);
        cyc(); see("t1_w1", 4'b0010, 1'b1, 8'hA1);
        cyc(); req_data = 32'h0000A200; see("t1_w2", 4'b0010, 1'b1, 8'hA2);
        cyc(); req_data = 32'h0000A300; see("t1_w3", 4'b0010, 1'b1, 8'hA3);
        cyc(); req = 4'b0000; see("t1_rel", 4'b0010, 1'b0, 8'hA3);
        cyc(); see("t1_end", 4'b0, 1'b0, 8'h00);

        do_reset();
        req = 4'b1111; req_data = 32'h13121110;
        for (int g = 0; g < 5; g++) begin
            see("t2_gap", 4'b0, 1'b0, 8'h00);
            for (int b = 0; b < 4; b++) begin
                cyc();
                see($sformatf("t2_o%0d_b%0d", g % 4, b), 4'(1 << (g % 4)), 1'b1, 8'(8'h10 + g % 4));
            end
            cyc();
        end
        req = 4'b0000;
        see("t2_end", 4'b0, 1'b0, 8'h00);
        cyc();

        req = 4'b0001; req_data = 32'h00000030;
        cyc(); see("t3_w1", 4'b0001, 1'b1, 8'h30);
        cyc(); see("t3_w2", 4'b0001, 1'b1, 8'h30);
        cyc(); full = 1;
        for (int s = 0; s < 5; s++) begin
            see($sformatf("t3_stall%0d", s), 4'b0001, 1'b0, 8'h30);
            cyc();
        end
        full = 0;
        see("t3_w3", 4'b0001, 1'b1, 8'h30);
        cyc(); see("t3_w4", 4'b0001, 1'b1, 8'h30);
        cyc(); see("t3_rot", 4'b0, 1'b0, 8'h00);
        req = 4'b0000;
        cyc();

        req = 4'b0100; req_data = 32'hD0C000B0;
        cyc(); see("t4_w", 4'b0100, 1'b1, 8'hC0);
        cyc(); req = 4'b1001; see("t4_rel2", 4'b0100, 1'b0, 8'hC0);
        cyc(); see("t4_idle", 4'b0, 1'b0, 8'h00);
        cyc(); req = 4'b0001; see("t4_g3", 4'b1000, 1'b0, 8'hD0);
        cyc(); see("t4_idle2", 4'b0, 1'b0, 8'h00);
        cyc(); see("t4_g0", 4'b0001, 1'b1, 8'hB0);
        cyc(); req = 4'b0000; see("t4_rel0", 4'b0001, 1'b0, 8'hB0);
        cyc(); see("t4_end", 4'b0, 1'b0, 8'h00);

        req = 4'b0010; req_data = 32'h0000E1E0;
        cyc(); see("t5_w1", 4'b0010, 1'b1, 8'hE1);
        cyc(); w_rst_n = 0; see("t5_rst_mid", 4'b0010, 1'b0, 8'hE1);
        cyc(); see("t5_rst", 4'b0, 1'b0, 8'h00);
        w_rst_n = 1; req = 4'b0011;
        cyc(); see("t5_g0", 4'b0001, 1'b1, 8'hE0);
        cyc(); req = 4'b0000; see("t5_rel", 4'b0001, 1'b0, 8'hE0);
        cyc(); see("t5_end", 4'b0, 1'b0, 8'h00);

        req = 4'b0100; req_data = 32'hF3F2F1F0;
        cyc(); req = 4'b0000; see("t6_nowr", 4'b0100, 1'b0, 8'hF2);
        cyc(); see("t6_idle", 4'b0, 1'b0, 8'h00);
        req = 4'b1011;
        cyc(); see("t6_g3", 4'b1000, 1'b1, 8'hF3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
